control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_ctrl_pkg.sv | 97 +++++++++
 rtl/control_unit.sv | 172 +++++++++++++++++
 tb/tb_control_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit: state encoding,
// instruction decode constants, ALU op codes, datapath mux selects.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ST_W    = 5;
  localparam int unsigned ALUOP_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_RESET      = 5'd0,
    ST_FETCH      = 5'd1,
    ST_MEM_WAIT_F = 5'd2,
    ST_IR_LOAD    = 5'd3,
    ST_DECODE     = 5'd4,
    ST_R_EXEC     = 5'd5,
    ST_R_WB       = 5'd6,
    ST_ADDI_EXEC  = 5'd7,
    ST_I_WB       = 5'd8,
    ST_ADDR_CALC  = 5'd9,
    ST_MEM_RD     = 5'd10,
    ST_MEM_WAIT_D = 5'd11,
    ST_LW_WB      = 5'd12,
    ST_MEM_WR     = 5'd13,
    ST_BRANCH     = 5'd14,
    ST_JUMP       = 5'd15,
    ST_EXC        = 5'd16
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;

  localparam logic [ALUOP_W-1:0] ALU_PASS_A = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD    = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SUB    = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND    = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_CMP    = 3'b111;

  localparam logic [1:0] IORD_PC      = 2'b00;
  localparam logic [1:0] IORD_ALUOUT  = 2'b01;
  localparam logic [1:0] REGDST_RT    = 2'b00;
  localparam logic [1:0] REGDST_RD    = 2'b01;
  localparam logic [2:0] M2R_ALUOUT   = 3'b000;
  localparam logic [2:0] M2R_MEM      = 3'b001;
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_A       = 1'b1;
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_00FC;

  typedef struct packed {
    logic               pc_load;
    logic               mem_write;
    logic               ir_load;
    logic               reg_write;
    logic               regA_load;
    logic               regB_load;
    logic               aluout_load;
    logic [1:0]         iord_sel;
    logic [1:0]         reg_dst_sel;
    logic [2:0]         mem_to_reg_sel;
    logic               alu_srcA_sel;
    logic [1:0]         alu_srcB_sel;
    logic [1:0]         pc_src_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal_op;
  } ctrl_t;

  function automatic logic r_funct_ok(input logic [OP_W-1:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
  endfunction

  function automatic logic [ALUOP_W-1:0] r_alu_op(input logic [OP_W-1:0] fn);
    case (fn)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Moore control FSM for the multicycle CPU datapath. Outputs are decoded from
// the next state and registered so they are valid the cycle a state is entered.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  output logic               pc_load,
  output logic               mem_write,
  output logic               ir_load,
  output logic               reg_write,
  output logic               regA_load,
  output logic               regB_load,
  output logic               aluout_load,
  output logic [1:0]         iord_sel,
  output logic [1:0]         reg_dst_sel,
  output logic [2:0]         mem_to_reg_sel,
  output logic               alu_srcA_sel,
  output logic [1:0]         alu_srcB_sel,
  output logic [1:0]         pc_src_sel,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op,
  output logic [ST_W-1:0]    state_dbg
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   br_take_c;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:      state_d = ST_FETCH;
      ST_FETCH:      state_d = ST_MEM_WAIT_F;
      ST_MEM_WAIT_F: state_d = ST_IR_LOAD;
      ST_IR_LOAD:    state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = ST_R_EXEC;
          OP_ADDI:       state_d = ST_ADDI_EXEC;
          OP_LW, OP_SW:  state_d = ST_ADDR_CALC;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_J:          state_d = ST_JUMP;
          default:       state_d = ST_EXC;
        endcase
      end
      // and never traps on overflow; add/sub do, and so do unknown functs
      ST_R_EXEC: begin
        if (!r_funct_ok(funct) || (alu_overflow && (funct != FN_AND)))
          state_d = ST_EXC;
        else
          state_d = ST_R_WB;
      end
      ST_ADDI_EXEC:  state_d = alu_overflow ? ST_EXC : ST_I_WB;
      ST_ADDR_CALC:  state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:     state_d = ST_MEM_WAIT_D;
      ST_MEM_WAIT_D: state_d = ST_LW_WB;
      default:       state_d = ST_FETCH;
    endcase
  end

  // Output decode for the state about to be entered
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_FETCH: begin
        ctrl_d.pc_load      = 1'b1;
        ctrl_d.iord_sel     = IORD_PC;
        ctrl_d.alu_srcA_sel = SRCA_PC;
        ctrl_d.alu_srcB_sel = SRCB_FOUR;
        ctrl_d.alu_op       = ALU_ADD;
        ctrl_d.pc_src_sel   = PCSRC_ALU;
      end
      ST_IR_LOAD: ctrl_d.ir_load = 1'b1;
      ST_DECODE: begin
        ctrl_d.regA_load    = 1'b1;
        ctrl_d.regB_load    = 1'b1;
        ctrl_d.alu_srcA_sel = SRCA_PC;
        ctrl_d.alu_srcB_sel = SRCB_IMM_SH2;
        ctrl_d.alu_op       = ALU_ADD;
        ctrl_d.aluout_load  = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl_d.alu_srcA_sel = SRCA_A;
        ctrl_d.alu_srcB_sel = SRCB_B;
        ctrl_d.alu_op       = r_alu_op(funct);
        ctrl_d.aluout_load  = 1'b1;
      end
      ST_R_WB: begin
        ctrl_d.reg_dst_sel    = REGDST_RD;
        ctrl_d.mem_to_reg_sel = M2R_ALUOUT;
        ctrl_d.reg_write      = 1'b1;
      end
      ST_ADDI_EXEC, ST_ADDR_CALC: begin
        ctrl_d.alu_srcA_sel = SRCA_A;
        ctrl_d.alu_srcB_sel = SRCB_IMM;
        ctrl_d.alu_op       = ALU_ADD;
        ctrl_d.aluout_load  = 1'b1;
      end
      ST_I_WB: begin
        ctrl_d.reg_dst_sel    = REGDST_RT;
        ctrl_d.mem_to_reg_sel = M2R_ALUOUT;
        ctrl_d.reg_write      = 1'b1;
      end
      // address stays on ALUOut while memory returns the load data
      ST_MEM_RD, ST_MEM_WAIT_D: ctrl_d.iord_sel = IORD_ALUOUT;
      ST_LW_WB: begin
        ctrl_d.reg_dst_sel    = REGDST_RT;
        ctrl_d.mem_to_reg_sel = M2R_MEM;
        ctrl_d.reg_write      = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl_d.iord_sel  = IORD_ALUOUT;
        ctrl_d.mem_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_d.alu_srcA_sel = SRCA_A;
        ctrl_d.alu_srcB_sel = SRCB_B;
        ctrl_d.alu_op       = ALU_SUB;
        ctrl_d.pc_src_sel   = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl_d.pc_load    = 1'b1;
        ctrl_d.pc_src_sel = PCSRC_JUMP;
      end
      ST_EXC: begin
        ctrl_d.pc_load    = 1'b1;
        ctrl_d.pc_src_sel = PCSRC_EXC;
        ctrl_d.illegal_op = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Branch outcome is only known from the ALU flags during BRANCH itself
  assign br_take_c = (state_q == ST_BRANCH) &&
                     (((opcode == OP_BEQ) && alu_zero) ||
                      ((opcode == OP_BNE) && !alu_zero));

  assign pc_load        = ctrl_q.pc_load | br_take_c;
  assign mem_write      = ctrl_q.mem_write;
  assign ir_load        = ctrl_q.ir_load;
  assign reg_write      = ctrl_q.reg_write;
  assign regA_load      = ctrl_q.regA_load;
  assign regB_load      = ctrl_q.regB_load;
  assign aluout_load    = ctrl_q.aluout_load;
  assign iord_sel       = ctrl_q.iord_sel;
  assign reg_dst_sel    = ctrl_q.reg_dst_sel;
  assign mem_to_reg_sel = ctrl_q.mem_to_reg_sel;
  assign alu_srcA_sel   = ctrl_q.alu_srcA_sel;
  assign alu_srcB_sel   = ctrl_q.alu_srcB_sel;
  assign pc_src_sel     = ctrl_q.pc_src_sel;
  assign alu_op         = ctrl_q.alu_op;
  assign illegal_op     = ctrl_q.illegal_op;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction cycle traces built
// from the instruction-level rules, directed corner cases plus random mix.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_load;
    logic       mem_write;
    logic       ir_load;
    logic       reg_write;
    logic       regA_load;
    logic       regB_load;
    logic       aluout_load;
    logic [1:0] iord_sel;
    logic [1:0] reg_dst_sel;
    logic [2:0] mem_to_reg_sel;
    logic       alu_srcA_sel;
    logic [1:0] alu_srcB_sel;
    logic [1:0] pc_src_sel;
    logic [2:0] alu_op;
    logic       illegal_op;
  } exp_t;

  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic       alu_zero, alu_overflow;
  logic       pc_load, mem_write, ir_load, reg_write, regA_load, regB_load, aluout_load;
  logic [1:0] iord_sel, reg_dst_sel, alu_srcB_sel, pc_src_sel;
  logic [2:0] mem_to_reg_sel, alu_op;
  logic       alu_srcA_sel, illegal_op;
  logic [4:0] state_dbg;
  exp_t       obs;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .pc_load(pc_load), .mem_write(mem_write), .ir_load(ir_load),
    .reg_write(reg_write), .regA_load(regA_load), .regB_load(regB_load),
    .aluout_load(aluout_load), .iord_sel(iord_sel), .reg_dst_sel(reg_dst_sel),
    .mem_to_reg_sel(mem_to_reg_sel), .alu_srcA_sel(alu_srcA_sel),
    .alu_srcB_sel(alu_srcB_sel), .pc_src_sel(pc_src_sel), .alu_op(alu_op),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs.pc_load        = pc_load;
    obs.mem_write      = mem_write;
    obs.ir_load        = ir_load;
    obs.reg_write      = reg_write;
    obs.regA_load      = regA_load;
    obs.regB_load      = regB_load;
    obs.aluout_load    = aluout_load;
    obs.iord_sel       = iord_sel;
    obs.reg_dst_sel    = reg_dst_sel;
    obs.mem_to_reg_sel = mem_to_reg_sel;
    obs.alu_srcA_sel   = alu_srcA_sel;
    obs.alu_srcB_sel   = alu_srcB_sel;
    obs.pc_src_sel     = pc_src_sel;
    obs.alu_op         = alu_op;
    obs.illegal_op     = illegal_op;
  end

  function automatic logic [4:0] pulses(input exp_t e);
    return {e.pc_load, e.mem_write, e.ir_load, e.reg_write, e.illegal_op};
  endfunction

  function automatic exp_t v_exc();
    exp_t e = '0;
    e.pc_load = 1'b1; e.pc_src_sel = 2'b11; e.illegal_op = 1'b1;
    return e;
  endfunction

  function automatic exp_t v_imm_add();
    exp_t e = '0;
    e.alu_srcA_sel = 1'b1; e.alu_srcB_sel = 2'b10; e.alu_op = 3'b001; e.aluout_load = 1'b1;
    return e;
  endfunction

  // Build the expected cycle trace of one instruction, then walk it
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic ov, input string tag);
    exp_t steps[$];
    bit   full[$];
    exp_t e;
    logic r_ok;
    opcode = op; funct = fn; alu_zero = z; alu_overflow = ov;

    e = '0; e.pc_load = 1'b1; e.alu_srcB_sel = 2'b01; e.alu_op = 3'b001;
    steps.push_back(e); full.push_back(1'b1);
    e = '0;
    steps.push_back(e); full.push_back(1'b1);
    e = '0; e.ir_load = 1'b1;
    steps.push_back(e); full.push_back(1'b1);
    e = '0; e.regA_load = 1'b1; e.regB_load = 1'b1; e.alu_srcB_sel = 2'b11;
    e.alu_op = 3'b001; e.aluout_load = 1'b1;
    steps.push_back(e); full.push_back(1'b1);

    case (op)
      6'h00: begin
        r_ok = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24);
        e = '0; e.alu_srcA_sel = 1'b1; e.aluout_load = 1'b1;
        e.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
        steps.push_back(e); full.push_back(r_ok);
        if (!r_ok || (ov && fn != 6'h24)) begin
          steps.push_back(v_exc()); full.push_back(1'b1);
        end else begin
          e = '0; e.reg_dst_sel = 2'b01; e.reg_write = 1'b1;
          steps.push_back(e); full.push_back(1'b1);
        end
      end
      6'h08: begin
        steps.push_back(v_imm_add()); full.push_back(1'b1);
        if (ov) e = v_exc();
        else begin e = '0; e.reg_write = 1'b1; end
        steps.push_back(e); full.push_back(1'b1);
      end
      6'h23: begin
        steps.push_back(v_imm_add()); full.push_back(1'b1);
        e = '0; e.iord_sel = 2'b01;
        steps.push_back(e); full.push_back(1'b1);
        e = '0;
        steps.push_back(e); full.push_back(1'b0);
        e = '0; e.mem_to_reg_sel = 3'b001; e.reg_write = 1'b1;
        steps.push_back(e); full.push_back(1'b1);
      end
      6'h2B: begin
        steps.push_back(v_imm_add()); full.push_back(1'b1);
        e = '0; e.iord_sel = 2'b01; e.mem_write = 1'b1;
        steps.push_back(e); full.push_back(1'b1);
      end
      6'h04, 6'h05: begin
        e = '0; e.alu_srcA_sel = 1'b1; e.alu_op = 3'b010; e.pc_src_sel = 2'b01;
        e.pc_load = (op == 6'h04) ? z : !z;
        steps.push_back(e); full.push_back(1'b1);
      end
      6'h02: begin
        e = '0; e.pc_load = 1'b1; e.pc_src_sel = 2'b10;
        steps.push_back(e); full.push_back(1'b1);
      end
      default: begin
        steps.push_back(v_exc()); full.push_back(1'b1);
      end
    endcase

    foreach (steps[i]) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) begin
        checks++;
        assert (state_dbg === 5'(ST_FETCH)) else begin
          errors++;
          $error("FAIL %s fetch_state: got %0d expected %0d", tag, state_dbg, 5'(ST_FETCH));
        end
      end
      checks++;
      if (full[i]) begin
        assert (obs === steps[i]) else begin
          errors++;
          $error("FAIL %s op=%h fn=%h z=%b ov=%b cycle %0d: got %h expected %h",
                 tag, op, fn, z, ov, i + 1, obs, steps[i]);
        end
      end else begin
        assert (pulses(obs) === pulses(steps[i])) else begin
          errors++;
          $error("FAIL %s op=%h fn=%h cycle %0d pulses: got %b expected %b",
                 tag, op, fn, i + 1, pulses(obs), pulses(steps[i]));
        end
      end
    end
  endtask

  task automatic check_reset(input string tag);
    checks++;
    assert (obs === exp_t'(0)) else begin
      errors++;
      $error("FAIL %s outputs: got %h expected 0", tag, obs);
    end
    checks++;
    assert (state_dbg === 5'(ST_RESET)) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, state_dbg, 5'(ST_RESET));
    end
  endtask

  initial begin
    int unsigned k;
    logic [5:0]  op, fn;
    logic        z, ov;

    rst = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; alu_overflow = 1'b0;
    #3;
    check_reset("por_async");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_reset("por_release");

    run_instr(6'h00, 6'h20, 1'b0, 1'b0, "add_ok");
    run_instr(6'h00, 6'h20, 1'b0, 1'b1, "add_ovf");
    run_instr(6'h00, 6'h22, 1'b1, 1'b1, "sub_ovf");
    run_instr(6'h00, 6'h24, 1'b0, 1'b1, "and_ovf_ignored");
    run_instr(6'h00, 6'h3F, 1'b0, 1'b0, "bad_funct");
    run_instr(6'h08, 6'h00, 1'b0, 1'b0, "addi_ok");
    run_instr(6'h08, 6'h00, 1'b0, 1'b1, "addi_ovf");
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, "lw");
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0, "sw");
    run_instr(6'h04, 6'h00, 1'b1, 1'b0, "beq_taken");
    run_instr(6'h04, 6'h00, 1'b0, 1'b0, "beq_not");
    run_instr(6'h05, 6'h00, 1'b1, 1'b0, "bne_not");
    run_instr(6'h05, 6'h00, 1'b0, 1'b0, "bne_taken");
    run_instr(6'h02, 6'h00, 1'b0, 1'b0, "jump");
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0, "illegal_op");

    // Abort an add in DECODE with an asynchronous reset
    opcode = 6'h00; funct = 6'h20; alu_zero = 1'b0; alu_overflow = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset("mid_decode_async");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_reset("mid_decode_release");
    run_instr(6'h00, 6'h22, 1'b0, 1'b0, "sub_after_reset");

    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 8);
      case (k)
        0, 1:    op = 6'h00;
        2:       op = 6'h08;
        3:       op = 6'h23;
        4:       op = 6'h2B;
        5:       op = 6'h04;
        6:       op = 6'h05;
        7:       op = 6'h02;
        default: op = 6'($urandom_range(0, 63));
      endcase
      k = $urandom_range(0, 3);
      case (k)
        0:       fn = 6'h20;
        1:       fn = 6'h22;
        2:       fn = 6'h24;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      z  = 1'($urandom_range(0, 1));
      ov = ($urandom_range(0, 3) == 0);
      run_instr(op, fn, z, ov, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
